magic_ctrl: RTL

- Sequences entry to and exit from "magic" service mode, which configures the I/O port decoder and memory mapper through `magic_map`.
- Flow: debounced press of the magic button → NMI to the Z80 → `magic_map` asserted on the NMI vector fetch (#0066) → exit armed by an I/O write to the exit port → `magic_map` released after the RETN that leaves the service routine.
- Sits between the CPU bus snoop and the ports/mapper blocks; it is the only source of `magic_map`.

---
 rtl/magic_ctrl_if.sv | 31 +++
 rtl/magic_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/magic_ctrl_if.sv
// Snooped Z80 CPU bus: address, data and the active-high strobes
// as seen by the magic-mode sequencer.
interface cpu_bus;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;
    logic        mreq;
    logic        ioreq;
    logic        m1;
    logic        rd;
    logic        wr;

    modport snoop (
        input a_reg,
        input d_reg,
        input mreq,
        input ioreq,
        input m1,
        input rd,
        input wr
    );

    modport cpu (
        output a_reg,
        output d_reg,
        output mreq,
        output ioreq,
        output m1,
        output rd,
        output wr
    );
endinterface

// File: rtl/magic_ctrl.sv
// Magic service-mode sequencer: button -> NMI -> map on #0066 fetch,
// unmap on the first fetch after RETN once exit has been armed.
module magic_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 280000,
    parameter int unsigned NMI_TIMEOUT     = 28000,
    parameter logic [15:0] EXIT_PORT       = 16'hFFF0
) (
    input  logic    clk28,
    input  logic    rst_n,
    cpu_bus.snoop   bus,
    input  logic    magic_en,
    input  logic    magic_button,
    output logic    nmi_n,
    output logic    magic_map,
    output logic    magic_timeout
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ?
                                 $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW = (NMI_TIMEOUT > 1) ?
                                 $clog2(NMI_TIMEOUT) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(NMI_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NMI,
        ST_MAPPED,
        ST_ARMED,
        ST_ED_SEEN,
        ST_RETN_DONE
    } state_e;

    logic          btn_s1_q;
    logic          btn_s2_q;
    logic [1:0]    sync_vld_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic [DW-1:0] deb_cnt_q;
    logic          rel_q;
    logic          press;

    logic          fetch;
    logic          fetch_q;
    logic          fetch_start;
    logic          fetch_end;
    logic [7:0]    opcode_q;
    logic          exit_hit;
    logic          exit_q;
    logic          exit_wr;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          nmi_n_q;
    logic          map_q;
    logic          timeout_q;

    // A button already held at reset must be seen released before a
    // debounced rise counts as a press.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            sync_vld_q <= 2'b00;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            rel_q      <= 1'b0;
        end else begin
            btn_s1_q   <= magic_button;
            btn_s2_q   <= btn_s1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            deb_prev_q <= deb_q;
            if (btn_s2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DB_LAST) begin
                deb_q     <= btn_s2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            if (sync_vld_q[1] && !btn_s2_q && !deb_q) begin
                rel_q <= 1'b1;
            end
        end
    end

    assign press = deb_q & ~deb_prev_q & rel_q;

    assign fetch       = bus.m1 & bus.mreq & bus.rd;
    assign fetch_start = fetch & ~fetch_q;
    assign fetch_end   = ~fetch & fetch_q;
    assign exit_hit    = bus.ioreq & bus.wr & (bus.a_reg == EXIT_PORT);
    assign exit_wr     = exit_hit & ~exit_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q  <= 1'b0;
            exit_q   <= 1'b0;
            opcode_q <= 8'h00;
        end else begin
            fetch_q <= fetch;
            exit_q  <= exit_hit;
            if (fetch) begin
                opcode_q <= bus.d_reg;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            nmi_n_q   <= 1'b1;
            map_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!magic_en) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                nmi_n_q <= 1'b1;
                map_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (press) begin
                            state_q <= ST_NMI;
                            timer_q <= '0;
                            nmi_n_q <= 1'b0;
                        end
                    end
                    ST_NMI: begin
                        if (fetch_start && bus.a_reg == 16'h0066) begin
                            state_q <= ST_MAPPED;
                            nmi_n_q <= 1'b1;
                            map_q   <= 1'b1;
                        end else if (timer_q == TO_LAST) begin
                            state_q   <= ST_IDLE;
                            nmi_n_q   <= 1'b1;
                            timeout_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    ST_MAPPED: begin
                        if (exit_wr) begin
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (fetch_end && opcode_q == 8'hED) begin
                            state_q <= ST_ED_SEEN;
                        end
                    end
                    ST_ED_SEEN: begin
                        if (fetch_end) begin
                            if (opcode_q == 8'h45) begin
                                state_q <= ST_RETN_DONE;
                            end else if (opcode_q != 8'hED) begin
                                state_q <= ST_ARMED;
                            end
                        end
                    end
                    ST_RETN_DONE: begin
                        // Unmap before the first user-code fetch reads data.
                        if (fetch_start) begin
                            state_q <= ST_IDLE;
                            map_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        nmi_n_q <= 1'b1;
                        map_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign nmi_n         = nmi_n_q;
    assign magic_map     = map_q;
    assign magic_timeout = timeout_q;

endmodule
